// File: rtl/pin_entry.sv
`default_nettype none
// ============================================================================
// Module   : pin_entry
// Brief    : Keypad front-end for the parking gate. Collects two BCD digits
//            while a vehicle is at the entry, presents the assembled code to
//            the gate controller for a fixed number of cycles, and flags
//            rejected entries (timeouts, premature ENTER, surplus or invalid
//            keys) with a one-cycle error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pin_entry #(
    parameter int TIMEOUT_CYCLES = 50,
    parameter int HOLD_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensorA,
    input  logic       keyPress,
    input  logic [3:0] keyCode,
    output logic [7:0] pass,
    output logic       passValid,
    output logic [1:0] digitCount,
    output logic       entryError
);

    localparam int c_timer_w = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int c_hold_w  = $clog2(HOLD_CYCLES) + 1;

    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timer_max    = {c_timer_w{1'b1}};
    localparam logic [c_hold_w-1:0]  c_hold_last    = c_hold_w'(HOLD_CYCLES - 1);

    localparam logic [3:0] c_key_clear = 4'hA;
    localparam logic [3:0] c_key_enter = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           hi_q, hi_d;
    logic [3:0]           lo_q, lo_d;
    logic [c_timer_w-1:0] timer_q, timer_d;
    logic [c_hold_w-1:0]  hold_q, hold_d;
    logic [7:0]           pass_q, pass_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [1:0]           count_q, count_d;
    logic                 key_prev_q;

    logic w_key_evt;
    logic w_is_digit;

    assign w_key_evt  = keyPress & ~key_prev_q;
    assign w_is_digit = (keyCode <= 4'd9);

    // Next-state and registered-output computation; sensor loss overrides keys.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        timer_d = timer_q;
        hold_d  = hold_q;
        pass_d  = pass_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        if (!sensorA) begin
            state_d = ST_IDLE;
            hi_d    = 4'd0;
            lo_d    = 4'd0;
            timer_d = '0;
            hold_d  = '0;
            pass_d  = 8'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ONE, ST_TWO: begin
                    if (w_key_evt) begin
                        if (w_is_digit) begin
                            timer_d = '0;
                            if (state_q == ST_IDLE) begin
                                hi_d    = keyCode;
                                state_d = ST_ONE;
                            end else if (state_q == ST_ONE) begin
                                lo_d    = keyCode;
                                state_d = ST_TWO;
                            end else begin
                                // Third digit is dropped; entry stays armed.
                                err_d = 1'b1;
                            end
                        end else if (keyCode == c_key_clear) begin
                            state_d = ST_IDLE;
                            hi_d    = 4'd0;
                            lo_d    = 4'd0;
                            timer_d = '0;
                        end else if (keyCode == c_key_enter) begin
                            if (state_q == ST_TWO) begin
                                pass_d  = {hi_q, lo_q};
                                valid_d = 1'b1;
                                hold_d  = '0;
                                state_d = ST_HOLD;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IDLE;
                                hi_d    = 4'd0;
                                lo_d    = 4'd0;
                                timer_d = '0;
                            end
                        end else begin
                            // Invalid key: flag it, leave everything else alone.
                            err_d = 1'b1;
                        end
                    end else if (state_q != ST_IDLE) begin
                        if (timer_q == c_timeout_last) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                            hi_d    = 4'd0;
                            lo_d    = 4'd0;
                            timer_d = '0;
                        end else if (timer_q != c_timer_max) begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Keys are ignored here; their edges are consumed by key_prev_q.
                    if (hold_q == c_hold_last) begin
                        state_d = ST_IDLE;
                        pass_d  = 8'd0;
                        valid_d = 1'b0;
                        hi_d    = 4'd0;
                        lo_d    = 4'd0;
                        hold_d  = '0;
                        timer_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_ONE:  count_d = 2'd1;
            ST_TWO:  count_d = 2'd2;
            ST_HOLD: count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= 4'd0;
            lo_q       <= 4'd0;
            timer_q    <= '0;
            hold_q     <= '0;
            pass_q     <= 8'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 2'd0;
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            timer_q    <= timer_d;
            hold_q     <= hold_d;
            pass_q     <= pass_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            count_q    <= count_d;
            key_prev_q <= keyPress;
        end
    end

    assign pass       = pass_q;
    assign passValid  = valid_q;
    assign digitCount = count_q;
    assign entryError = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_entry
// Brief    : Self-checking bench for pin_entry: directed scenarios followed by
//            randomized keypad/sensor/reset traffic, all compared every cycle
//            against a digit-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_entry;

    localparam int TIMEOUT = 50;
    localparam int HOLD    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sensorA = 1'b0;
    logic       keyPress = 1'b0;
    logic [3:0] keyCode = 4'd0;
    logic [7:0] pass;
    logic       passValid;
    logic [1:0] digitCount;
    logic       entryError;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: buffered digits, remaining presentation cycles,
    // cycles since the last accepted key, and the previous keyPress level.
    int         m_buf[$];
    int         m_hold_left = 0;
    int         m_idle = 0;
    bit         m_prev = 1'b0;
    logic [7:0] m_pass = 8'd0;
    bit         m_valid = 1'b0;
    bit         m_err = 1'b0;
    int         m_count = 0;

    pin_entry #(.TIMEOUT_CYCLES(TIMEOUT), .HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .sensorA    (sensorA),
        .keyPress   (keyPress),
        .keyCode    (keyCode),
        .pass       (pass),
        .passValid  (passValid),
        .digitCount (digitCount),
        .entryError (entryError)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Predicts the outputs visible after the coming clock edge.
    task automatic model_step(input bit rst_n, input bit s, input bit kp, input logic [3:0] kc);
        bit evt;
        if (!rst_n) begin
            m_buf.delete();
            m_hold_left = 0; m_idle = 0; m_prev = 1'b0;
            m_pass = 8'd0; m_valid = 1'b0; m_err = 1'b0; m_count = 0;
            return;
        end
        evt    = kp && !m_prev;
        m_prev = kp;
        m_err  = 1'b0;
        if (!s) begin
            m_buf.delete();
            m_hold_left = 0; m_idle = 0;
            m_pass = 8'd0; m_valid = 1'b0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_pass = 8'd0; m_valid = 1'b0;
                m_buf.delete();
                m_idle = 0;
            end
        end else if (evt) begin
            if (kc <= 4'd9) begin
                if (m_buf.size() < 2) m_buf.push_back(int'(kc));
                else m_err = 1'b1;
                m_idle = 0;
            end else if (kc == 4'hA) begin
                m_buf.delete();
                m_idle = 0;
            end else if (kc == 4'hB) begin
                if (m_buf.size() == 2) begin
                    m_pass = 8'(m_buf[0] * 16 + m_buf[1]);
                    m_valid = 1'b1;
                    m_hold_left = HOLD;
                end else begin
                    m_err = 1'b1;
                    m_buf.delete();
                    m_idle = 0;
                end
            end else begin
                m_err = 1'b1;
            end
        end else if (m_buf.size() > 0) begin
            if (m_idle == TIMEOUT - 1) begin
                m_err = 1'b1;
                m_buf.delete();
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
        m_count = (m_hold_left > 0) ? 2 : m_buf.size();
    endtask

    task automatic step(input bit rst_n, input bit s, input bit kp, input logic [3:0] kc);
        reset = rst_n; sensorA = s; keyPress = kp; keyCode = kc;
        model_step(rst_n, s, kp, kc);
        @(posedge clk);
        #1;
        check8("pass",       pass,                  m_pass);
        check8("passValid",  {7'd0, passValid},     {7'd0, m_valid});
        check8("digitCount", {6'd0, digitCount},    8'(m_count));
        check8("entryError", {7'd0, entryError},    {7'd0, m_err});
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b1, 1'b1, 1'b1, c);
        step(1'b1, 1'b1, 1'b0, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        bit         r_n, s, kp;
        logic [3:0] kc;

        // Reset and nominal entry "2","6",ENTER.
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        check8("reset_pass",  pass, 8'd0);
        check8("reset_count", {6'd0, digitCount}, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        key(4'd2);
        check8("nom_count1", {6'd0, digitCount}, 8'd1);
        key(4'd6);
        check8("nom_count2", {6'd0, digitCount}, 8'd2);
        step(1'b1, 1'b1, 1'b1, 4'hB);
        check8("nom_pass", pass, 8'h26);
        check8("nom_valid1", {7'd0, passValid}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 4'hB);
        check8("nom_valid2", {7'd0, passValid}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check8("nom_done_valid", {7'd0, passValid}, 8'd0);
        check8("nom_done_pass", pass, 8'd0);

        // Invalid keys interleaved with digits, then a clean retry.
        step(1'b1, 1'b1, 1'b1, 4'hF);
        check8("inv_err", {7'd0, entryError}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 4'hF);
        check8("inv_err_once", {7'd0, entryError}, 8'd0);
        key(4'd3); key(4'hE); key(4'hB);
        key(4'd2); key(4'd6);
        step(1'b1, 1'b1, 1'b1, 4'hB);
        check8("retry_pass", pass, 8'h26);
        idle(3);

        // Timeout: error exactly 50 cycles after the accepted key.
        key(4'd2);
        idle(48);
        check8("to_pending", {6'd0, digitCount}, 8'd1);
        idle(1);
        check8("to_err", {7'd0, entryError}, 8'd1);
        check8("to_count", {6'd0, digitCount}, 8'd0);
        // A key on cycle 49 restarts the timer.
        key(4'd2);
        idle(47);
        step(1'b1, 1'b1, 1'b1, 4'd3);
        check8("to_rescue_err", {7'd0, entryError}, 8'd0);
        check8("to_rescue_cnt", {6'd0, digitCount}, 8'd2);
        step(1'b1, 1'b1, 1'b0, 4'd3);
        idle(10);
        key(4'hA);

        // Premature ENTER and CLEAR.
        step(1'b1, 1'b1, 1'b1, 4'hB);
        check8("enter0_err", {7'd0, entryError}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 4'hB);
        key(4'd5);
        step(1'b1, 1'b1, 1'b1, 4'hB);
        check8("enter1_err", {7'd0, entryError}, 8'd1);
        check8("enter1_cnt", {6'd0, digitCount}, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'hB);
        key(4'd5); key(4'd1);
        step(1'b1, 1'b1, 1'b1, 4'hA);
        check8("clear_err", {7'd0, entryError}, 8'd0);
        check8("clear_cnt", {6'd0, digitCount}, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'hA);

        // Vehicle leaves in TWO and in HOLD; keys ignored while absent.
        key(4'd4); key(4'd5);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check8("leave_two_cnt", {6'd0, digitCount}, 8'd0);
        step(1'b1, 1'b0, 1'b1, 4'd7);
        step(1'b1, 1'b0, 1'b0, 4'd7);
        check8("absent_key_cnt", {6'd0, digitCount}, 8'd0);
        key(4'd8); key(4'd9);
        step(1'b1, 1'b1, 1'b1, 4'hB);
        step(1'b1, 1'b0, 1'b0, 4'hB);
        check8("leave_hold_valid", {7'd0, passValid}, 8'd0);
        check8("leave_hold_pass", pass, 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);

        // Held key yields a single digit.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 4'd7);
        check8("held_cnt", {6'd0, digitCount}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 4'd7);
        key(4'hA);

        // Reset during HOLD.
        key(4'd1); key(4'd2);
        step(1'b1, 1'b1, 1'b1, 4'hB);
        step(1'b0, 1'b1, 1'b0, 4'hB);
        check8("rst_hold_pass",  pass, 8'd0);
        check8("rst_hold_valid", {7'd0, passValid}, 8'd0);
        check8("rst_hold_cnt",   {6'd0, digitCount}, 8'd0);

        // Randomized traffic.
        kp = 1'b0;
        kc = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            r_n = ($urandom_range(0, 299) != 0);
            s   = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 2) == 0) begin
                kp = ~kp;
                if (kp) begin
                    case ($urandom_range(0, 9))
                        0:       kc = 4'hA;
                        1, 2:    kc = 4'hB;
                        3:       kc = 4'(12 + $urandom_range(0, 3));
                        default: kc = 4'($urandom_range(0, 9));
                    endcase
                end
            end
            step(r_n, s, kp, kc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
